alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 4-bit ALU between two requesters.
// Each operation takes three cycles: grant/launch (EXEC), capture/done (DONE), back to IDLE.
module alu_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic [2:0] cmd0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [2:0] cmd1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] res0,
    output logic [3:0] res1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_cmd,
    input  logic [3:0] alu_y,
    output logic       busy,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     r_state;
    logic       r_last_grant;
    logic       r_sel;
    logic       r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
    logic [3:0] r_res0, r_res1, r_alu_a, r_alu_b;
    logic [2:0] r_alu_cmd;
    logic [7:0] r_op_count;

    logic w_any;
    logic w_win;

    // Under contention the requester not served last wins; otherwise the lone requester.
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last_grant : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_busy       <= 1'b0;
            r_res0       <= 4'd0;
            r_res1       <= 4'd0;
            r_alu_a      <= 4'd0;
            r_alu_b      <= 4'd0;
            r_alu_cmd    <= 3'd0;
            r_op_count   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel        <= w_win;
                        r_last_grant <= w_win;
                        r_alu_a      <= w_win ? a1   : a0;
                        r_alu_b      <= w_win ? b1   : b0;
                        r_alu_cmd    <= w_win ? cmd1 : cmd0;
                        r_gnt0       <= ~w_win;
                        r_gnt1       <= w_win;
                        r_busy       <= 1'b1;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for a full cycle here.
                    if (r_sel) r_res1 <= alu_y;
                    else       r_res0 <= alu_y;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_done0    <= ~r_sel;
                    r_done1    <= r_sel;
                    r_op_count <= r_op_count + 8'd1;
                    r_state    <= DONE;
                end
                DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign busy     = r_busy;
    assign res0     = r_res0;
    assign res1     = r_res1;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_cmd  = r_alu_cmd;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// hand-written sequences for contention, late deassert, mid-op reset and counter wrap.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [2:0] cmd0, cmd1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [3:0] res0, res1, alu_a, alu_b, alu_y;
    logic [2:0] alu_cmd;
    logic [7:0] op_count;

    int n_chk = 0;
    int n_err = 0;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .cmd0(cmd0), .a0(a0), .b0(b0),
        .req1(req1), .cmd1(cmd1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_y(alu_y),
        .busy(busy), .op_count(op_count)
    );

    assign alu_y = alu_a ^ alu_b;

    always #5 clk = ~clk;

    typedef struct {
        logic       r0, r1;
        logic [2:0] c0, c1;
        logic [3:0] a0, b0, a1, b1;
        logic       w;
        logic [3:0] y;
    } vec_t;

    vec_t tbl[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " gnt0"}, gnt0, 0);
        chk({tag, " gnt1"}, gnt1, 0);
        chk({tag, " done0"}, done0, 0);
        chk({tag, " done1"}, done1, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " res0"}, res0, 0);
        chk({tag, " res1"}, res1, 0);
        chk({tag, " alu_a"}, alu_a, 0);
        chk({tag, " alu_b"}, alu_b, 0);
        chk({tag, " alu_cmd"}, alu_cmd, 0);
        chk({tag, " op_count"}, op_count, 0);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e_res0, e_res1;
        int         who[8];
        int         when[8];
        int         nd, ovl, ndone0;
        logic [1:0] exp_who;

        // winner and result are hand-computed; last_grant starts at 1
        tbl[0] = '{1'b1, 1'b0, 3'd0, 3'd1, 4'h2, 4'hC, 4'h7, 4'h7, 1'b0, 4'hE};
        tbl[1] = '{1'b1, 1'b1, 3'd2, 3'd3, 4'h5, 4'h3, 4'h3, 4'hA, 1'b1, 4'h9};
        tbl[2] = '{1'b1, 1'b1, 3'd7, 3'd1, 4'h5, 4'h3, 4'h3, 4'hA, 1'b0, 4'h6};
        tbl[3] = '{1'b0, 1'b1, 3'd6, 3'd5, 4'h1, 4'h8, 4'hF, 4'h0, 1'b1, 4'hF};
        tbl[4] = '{1'b0, 1'b1, 3'd6, 3'd2, 4'h1, 4'h8, 4'h1, 4'h1, 1'b1, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 3'd3, 3'd4, 4'h8, 4'h1, 4'h2, 4'h2, 1'b0, 4'h9};
        tbl[6] = '{1'b1, 1'b0, 3'd4, 3'd7, 4'hF, 4'hF, 4'hC, 4'h3, 1'b0, 4'h0};
        tbl[7] = '{1'b1, 1'b1, 3'd5, 3'd6, 4'h4, 4'h4, 4'h6, 4'h9, 1'b1, 4'hF};

        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        reset_n = 1'b0;
        #3;
        chk_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;

        // Table-driven single operations
        e_res0 = 4'h0;
        e_res1 = 4'h0;
        for (int i = 0; i < 8; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            cmd0 = tbl[i].c0; cmd1 = tbl[i].c1;
            a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
            tick();
            chk($sformatf("v%0d gnt0", i), gnt0, !tbl[i].w);
            chk($sformatf("v%0d gnt1", i), gnt1, tbl[i].w);
            chk($sformatf("v%0d alu_a", i), alu_a, tbl[i].w ? tbl[i].a1 : tbl[i].a0);
            chk($sformatf("v%0d alu_b", i), alu_b, tbl[i].w ? tbl[i].b1 : tbl[i].b0);
            chk($sformatf("v%0d alu_cmd", i), alu_cmd, tbl[i].w ? tbl[i].c1 : tbl[i].c0);
            chk($sformatf("v%0d busy", i), busy, 1);
            req0 = 0; req1 = 0;
            tick();
            if (tbl[i].w) e_res1 = tbl[i].y;
            else          e_res0 = tbl[i].y;
            chk($sformatf("v%0d done0", i), done0, !tbl[i].w);
            chk($sformatf("v%0d done1", i), done1, tbl[i].w);
            chk($sformatf("v%0d res0", i), res0, e_res0);
            chk($sformatf("v%0d res1", i), res1, e_res1);
            chk($sformatf("v%0d op_count", i), op_count, i + 1);
            chk($sformatf("v%0d gnt_clr", i), {gnt0, gnt1}, 0);
            tick();
            chk($sformatf("v%0d done_clr", i), {done0, done1}, 0);
            chk($sformatf("v%0d idle_busy", i), busy, 0);
        end

        // Contention right after reset: requester 0 first, then 1
        do_reset();
        req0 = 1; a0 = 4'h2; b0 = 4'hC; cmd0 = 3'd0;
        req1 = 1; a1 = 4'h3; b1 = 4'hA; cmd1 = 3'd0;
        tick();
        chk("cont gnt0", gnt0, 1);
        chk("cont gnt1", gnt1, 0);
        chk("cont alu_a", alu_a, 4'h2);
        tick();
        chk("cont done0", done0, 1);
        chk("cont res0", res0, 4'hE);
        req0 = 0;
        tick();
        tick();
        chk("cont gnt1 2nd", gnt1, 1);
        chk("cont alu_b 2nd", alu_b, 4'hA);
        req1 = 0;
        tick();
        chk("cont done1", done1, 1);
        chk("cont res1", res1, 4'h9);
        chk("cont res0 held", res0, 4'hE);
        chk("cont op_count", op_count, 2);
        tick();

        // Continuous contention for 12 cycles
        req0 = 1; req1 = 1;
        nd = 0; ovl = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (gnt0 && gnt1) ovl++;
            if (done0 && done1) ovl++;
            if ((done0 || done1) && nd < 8) begin
                who[nd]  = done1 ? 1 : 0;
                when[nd] = c;
                nd++;
            end
        end
        req0 = 0; req1 = 0;
        chk("rr overlap", ovl, 0);
        chk("rr done count", nd, 4);
        for (int k = 0; k < 4 && k < nd; k++) begin
            exp_who = (k % 2 == 0) ? 2'd0 : 2'd1;
            chk($sformatf("rr who%0d", k), who[k], exp_who);
            if (k > 0) chk($sformatf("rr gap%0d", k), when[k] - when[k-1], 3);
        end
        chk("rr op_count", op_count, 6);
        tick();

        // Late deassert with operand change during EXEC
        req1 = 1; a1 = 4'h3; b1 = 4'hA; cmd1 = 3'd1;
        tick();
        chk("late gnt1", gnt1, 1);
        chk("late alu_b old", alu_b, 4'hA);
        chk("late alu_cmd", alu_cmd, 1);
        b1 = 4'h5;
        tick();
        chk("late done1", done1, 1);
        chk("late res1 old", res1, 4'h9);
        tick();
        chk("late idle gnt1", gnt1, 0);
        chk("late idle busy", busy, 0);
        tick();
        chk("late regrant gnt1", gnt1, 1);
        chk("late alu_b new", alu_b, 4'h5);
        req1 = 0;
        tick();
        chk("late done1 2nd", done1, 1);
        chk("late res1 new", res1, 4'h6);
        chk("late op_count", op_count, 8);
        tick();

        // Reset during EXEC drops the operation
        req1 = 1; a1 = 4'h7; b1 = 4'h1; cmd1 = 3'd3;
        tick();
        chk("mid gnt1 pre", gnt1, 1);
        req1 = 0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("mid async");
        tick();
        chk("mid no done0", done0, 0);
        chk("mid no done1", done1, 0);
        tick();
        chk_zero("mid held");
        reset_n = 1'b1;
        req1 = 1; a1 = 4'h4; b1 = 4'h1; cmd1 = 3'd2;
        tick();
        chk("post gnt1", gnt1, 1);
        chk("post alu_a", alu_a, 4'h4);
        req1 = 0;
        tick();
        chk("post done1", done1, 1);
        chk("post res1", res1, 4'h5);
        chk("post res0", res0, 4'h0);
        chk("post op_count", op_count, 1);
        tick();

        // Counter wrap over 256 operations
        do_reset();
        req0 = 1; a0 = 4'h1; b0 = 4'h2; cmd0 = 3'd0;
        ndone0 = 0;
        for (int c = 0; c < 1000 && ndone0 < 256; c++) begin
            tick();
            if (done0) begin
                ndone0++;
                if (ndone0 == 255) chk("wrap 255", op_count, 8'd255);
                if (ndone0 == 256) chk("wrap 0", op_count, 8'd0);
            end
        end
        req0 = 0;
        chk("wrap done count", ndone0, 256);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
